shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl_if.sv | 27 ++
 rtl/shift_ctrl.sv | 115 +++++++++++
 tb/tb_shift_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/shift_ctrl_if.sv
// rtl/shift_ctrl_if.sv - control/data bundle between shift_ctrl and its user plus SISO register
interface shift_ctrl_if #(parameter int N = 4);
  logic         start;
  logic         lsb_first;
  logic         dir_cfg;
  logic         pause;
  logic [N-1:0] data_in;
  logic         sr_q;
  logic         sr_clr;
  logic         sr_enable;
  logic         sr_dir;
  logic         sr_d;
  logic         busy;
  logic         done;
  logic [N-1:0] data_out;
  logic         match;

  modport slave (
    input  start, lsb_first, dir_cfg, pause, data_in, sr_q,
    output sr_clr, sr_enable, sr_dir, sr_d, busy, done, data_out, match
  );

  modport master (
    output start, lsb_first, dir_cfg, pause, data_in, sr_q,
    input  sr_clr, sr_enable, sr_dir, sr_d, busy, done, data_out, match
  );
endinterface

// File: rtl/shift_ctrl.sv
// rtl/shift_ctrl.sv - drives an N-bit SISO shift register: serialize a word, read it back, compare
module shift_ctrl #(parameter int N = 4) (
  input  logic clk_i,
  input  logic rst_ni,
  shift_ctrl_if.slave ctrl
);
  localparam int KW = $clog2(2 * N);
  localparam logic [KW-1:0] K_N    = KW'(N);
  localparam logic [KW-1:0] K_LAST = KW'(2 * N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0] data_q, data_d;
  logic         lsb_q, lsb_d;
  logic         dir_q, dir_d;
  logic [N-1:0] cap_q, cap_d;
  logic [N-1:0] out_q, out_d;
  logic         match_q, match_d;

  logic [KW-1:0] tx_bit;
  logic [KW-1:0] cap_idx;
  logic [KW-1:0] cap_bit;
  logic          sr_d_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      data_q  <= '0;
      lsb_q   <= 1'b0;
      dir_q   <= 1'b0;
      cap_q   <= '0;
      out_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      lsb_q   <= lsb_d;
      dir_q   <= dir_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
      match_q <= match_d;
    end
  end

  // Second half of SHIFT reads the word back in the same order it was sent.
  assign cap_idx = k_q - K_N;
  assign cap_bit = lsb_q ? cap_idx : (K_N - 1'b1 - cap_idx);
  assign tx_bit  = lsb_q ? k_q : (K_N - 1'b1 - k_q);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    lsb_d   = lsb_q;
    dir_d   = dir_q;
    cap_d   = cap_q;
    out_d   = out_q;
    match_d = match_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl.start) begin
          data_d  = ctrl.data_in;
          lsb_d   = ctrl.lsb_first;
          dir_d   = ctrl.dir_cfg;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cap_d   = '0;
        k_d     = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (!ctrl.pause) begin
          if (k_q >= K_N) begin
            for (int i = 0; i < N; i++) begin
              if (i == int'(cap_bit)) cap_d[i] = ctrl.sr_q;
            end
          end
          if (k_q == K_LAST) begin
            out_d   = cap_d;
            match_d = (cap_d == data_q);
            k_d     = '0;
            state_d = S_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sr_d_c = 1'b0;
    if (state_q == S_SHIFT && k_q < K_N) begin
      for (int i = 0; i < N; i++) begin
        if (i == int'(tx_bit)) sr_d_c = data_q[i];
      end
    end
  end

  assign ctrl.sr_clr    = (state_q == S_CLEAR);
  assign ctrl.sr_enable = (state_q == S_SHIFT) && !ctrl.pause;
  assign ctrl.sr_dir    = (state_q != S_IDLE) && dir_q;
  assign ctrl.sr_d      = sr_d_c;
  assign ctrl.busy      = (state_q != S_IDLE);
  assign ctrl.done      = (state_q == S_DONE);
  assign ctrl.data_out  = out_q;
  assign ctrl.match     = match_q;
endmodule

// File: tb/tb_shift_ctrl.sv
// tb/tb_shift_ctrl.sv - directed bench for shift_ctrl with a 4-stage SISO register model
module tb_shift_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic tie0;
  logic [3:0] model;
  int checks = 0;
  int errors = 0;

  logic [7:0] r_seq;
  int r_nen, r_done_cyc, r_done_w, r_clr_cnt, r_dir_bad, r_plow;
  logic r_clr_first;

  shift_ctrl_if #(.N(4)) ctrl ();

  shift_ctrl #(.N(4)) dut (.clk_i(clk), .rst_ni(rst_n), .ctrl(ctrl));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              model <= 4'b0;
    else if (ctrl.sr_clr)    model <= 4'b0;
    else if (ctrl.sr_enable) model <= {model[2:0], ctrl.sr_d};
  end
  assign ctrl.sr_q = tie0 ? 1'b0 : model[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {ctrl.sr_clr, ctrl.sr_enable, ctrl.sr_dir, ctrl.sr_d, ctrl.busy,
            ctrl.done, ctrl.match, ctrl.data_out};
  endfunction

  // Cycle 0 carries start; results are sampled 1ns after each falling edge.
  task automatic run_txn(input logic [3:0] d, input logic lsb, input logic dir,
                         input int p_at, input int p_len,
                         input int inj_at, input logic [3:0] inj_d, input logic tie);
    int paused;
    @(negedge clk);
    tie0 = tie; data_in_drive(d); ctrl.lsb_first = lsb; ctrl.dir_cfg = dir;
    ctrl.start = 1'b1; ctrl.pause = 1'b0;
    r_seq = '0; r_nen = 0; r_done_cyc = -1; r_done_w = 0; r_clr_cnt = 0;
    r_dir_bad = 0; r_plow = 0; r_clr_first = 1'b0; paused = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      ctrl.start = (c == inj_at);
      if (c == inj_at) begin
        data_in_drive(inj_d); ctrl.lsb_first = ~lsb; ctrl.dir_cfg = ~dir;
      end else if (c == 1) begin
        data_in_drive(~d);
      end
      if (c == 1) ctrl.pause = 1'b1;
      else if (p_len > 0 && r_nen == p_at && paused < p_len) begin
        ctrl.pause = 1'b1; paused++;
      end else ctrl.pause = 1'b0;
      #1;
      if (c == 1) r_clr_first = ctrl.sr_clr && !ctrl.sr_enable;
      if (ctrl.sr_clr) r_clr_cnt++;
      if (ctrl.sr_enable) begin r_seq = {r_seq[6:0], ctrl.sr_d}; r_nen++; end
      if (ctrl.pause && c > 1 && ctrl.busy && !ctrl.sr_enable) r_plow++;
      if (ctrl.busy && ctrl.sr_dir !== dir) r_dir_bad++;
      if (ctrl.done) begin
        if (r_done_cyc < 0) r_done_cyc = c;
        r_done_w++;
      end
    end
    ctrl.pause = 1'b0; ctrl.start = 1'b0; tie0 = 1'b0;
  endtask

  task automatic data_in_drive(input logic [3:0] v);
    ctrl.data_in = v;
  endtask

  initial begin
    rst_n = 1'b0; tie0 = 1'b0;
    ctrl.start = 1'b0; ctrl.lsb_first = 1'b0; ctrl.dir_cfg = 1'b0;
    ctrl.pause = 1'b0; ctrl.data_in = 4'h0;
    #1;
    chk("reset_outs", 32'(outs()), 32'h0);
    #11 rst_n = 1'b1;

    run_txn(4'b1011, 1'b1, 1'b0, -1, 0, -1, 4'h0, 1'b0);
    chk("t1_seq", 32'(r_seq), 32'hD0);
    chk("t1_nen", 32'(r_nen), 32'd8);
    chk("t1_clr_first", 32'(r_clr_first), 32'd1);
    chk("t1_clr_cnt", 32'(r_clr_cnt), 32'd1);
    chk("t1_done_cyc", 32'(r_done_cyc), 32'd10);
    chk("t1_done_w", 32'(r_done_w), 32'd1);
    chk("t1_data_out", 32'(ctrl.data_out), 32'hB);
    chk("t1_match", 32'(ctrl.match), 32'd1);
    chk("t1_busy", 32'(ctrl.busy), 32'd0);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("idle_reset_outs", 32'(outs()), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    run_txn(4'b1000, 1'b0, 1'b1, -1, 0, -1, 4'h0, 1'b0);
    chk("t2_seq", 32'(r_seq), 32'h80);
    chk("t2_dir_bad", 32'(r_dir_bad), 32'd0);
    chk("t2_done_cyc", 32'(r_done_cyc), 32'd10);
    chk("t2_data_out", 32'(ctrl.data_out), 32'h8);
    chk("t2_match", 32'(ctrl.match), 32'd1);
    chk("t2_sr_dir_idle", 32'(ctrl.sr_dir), 32'd0);

    run_txn(4'b0110, 1'b1, 1'b0, 5, 3, -1, 4'h0, 1'b0);
    chk("t3_pause_low", 32'(r_plow), 32'd3);
    chk("t3_nen", 32'(r_nen), 32'd8);
    chk("t3_seq", 32'(r_seq), 32'h60);
    chk("t3_done_cyc", 32'(r_done_cyc), 32'd13);
    chk("t3_done_w", 32'(r_done_w), 32'd1);
    chk("t3_data_out", 32'(ctrl.data_out), 32'h6);
    chk("t3_match", 32'(ctrl.match), 32'd1);

    run_txn(4'b1011, 1'b1, 1'b0, -1, 0, 4, 4'b0100, 1'b0);
    chk("t4_seq", 32'(r_seq), 32'hD0);
    chk("t4_dir_bad", 32'(r_dir_bad), 32'd0);
    chk("t4_done_cyc", 32'(r_done_cyc), 32'd10);
    chk("t4_data_out", 32'(ctrl.data_out), 32'hB);
    chk("t4_match", 32'(ctrl.match), 32'd1);

    @(negedge clk);
    ctrl.data_in = 4'b1101; ctrl.lsb_first = 1'b1; ctrl.dir_cfg = 1'b1; ctrl.start = 1'b1;
    @(negedge clk) ctrl.start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_busy", 32'(ctrl.busy), 32'd1);
    chk("mid_enable", 32'(ctrl.sr_enable), 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_reset_outs", 32'(outs()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ctrl.start = 1'b1;
    @(negedge clk);
    ctrl.start = 1'b0;
    #1;
    chk("post_reset_clr", 32'(ctrl.sr_clr), 32'd1);
    chk("post_reset_busy", 32'(ctrl.busy), 32'd1);
    repeat (12) @(negedge clk);

    run_txn(4'b0110, 1'b1, 1'b0, -1, 0, -1, 4'h0, 1'b1);
    chk("t5_seq", 32'(r_seq), 32'h60);
    chk("t5_done_cyc", 32'(r_done_cyc), 32'd10);
    chk("t5_done_w", 32'(r_done_w), 32'd1);
    chk("t5_data_out", 32'(ctrl.data_out), 32'h0);
    chk("t5_match", 32'(ctrl.match), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
